// File: rtl/rom_ctrl_pkg.sv
// Shared types and widths for the ROM read arbiter.
// Ports: none (package). Provides ROM_AW, ROM_DW, address/data types and the controller state enum.
// Imported by the interface, the arbiter sub-module and the top.
package rom_ctrl_pkg;

    localparam int ROM_AW = 15;
    localparam int ROM_DW = 8;

    typedef logic [ROM_AW-1:0] rom_addr_t;
    typedef logic [ROM_DW-1:0] rom_data_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Bundle of requester handshakes and ROM pins for the ROM read arbiter.
// Ports: req0/req1 valid+addr in, ready/rsp strobes + rsp_data out; ROM nrst/cs/en/ad out, rom_do in.
// slave = arbiter side, master = requesters plus ROM side.
interface rom_read_arbiter_if;
    import rom_ctrl_pkg::*;

    logic      req0_valid;
    logic      req1_valid;
    rom_addr_t req0_addr;
    rom_addr_t req1_addr;
    logic      req0_ready;
    logic      req1_ready;
    logic      rsp0_valid;
    logic      rsp1_valid;
    rom_data_t rsp_data;
    logic      rom_nrst;
    logic      rom_cs;
    logic      rom_en;
    rom_addr_t rom_ad;
    rom_data_t rom_do;

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, rom_do,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
               rom_nrst, rom_cs, rom_en, rom_ad
    );

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, rom_do,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
               rom_nrst, rom_cs, rom_en, rom_ad
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Ports: valid0/valid1 request flags, last_grant (1 = requester 1 won last), grant one-hot out.
// On a tie the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Arbitrates two read requesters onto one strobed ROM; response ACCESS_CYCLES+3 cycles after accept.
// Ports: clk, rst (async, active high), bus (slave modport: requester handshakes and ROM pins).
// One request in flight; ready only in IDLE. Optional macro ROM_REUSE_EN adds a last-address hit path.
module rom_read_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    rom_read_arbiter_if.slave   bus
);

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    state_t    state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic      last_q, last_d;     // 1 = requester 1 was granted last
    logic      gnt_q, gnt_d;       // requester owning the access in flight
    rom_addr_t ad_q, ad_d;
    rom_data_t data_q, data_d;

    logic [1:0] grant;
    rom_addr_t  sel_addr;
    logic       hit;

    rr_arbiter2 u_rr (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;

`ifdef ROM_REUSE_EN
    // Address of the most recent completed ROM read; rsp_data still holds its word.
    rom_addr_t tag_q;
    logic      tag_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else if (state_q == CAPTURE) begin
            tag_q     <= ad_q;
            tag_vld_q <= 1'b1;
        end
    end

    assign hit = tag_vld_q && (sel_addr == tag_q);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            ad_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ad_q    <= ad_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        gnt_d          = gnt_q;
        ad_d           = ad_q;
        data_d         = data_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rom_nrst   = 1'b1;
        bus.rom_cs     = 1'b0;
        bus.rom_en     = 1'b1;

        case (state_q)
            INIT: begin
                // ROM held in reset for the single cycle following reset release
                bus.rom_nrst = 1'b0;
                state_d      = IDLE;
            end
            IDLE: begin
                if (|grant) begin
                    bus.req0_ready = grant[0];
                    bus.req1_ready = grant[1];
                    last_d         = grant[1];
                    gnt_d          = grant[1];
                    ad_d           = sel_addr;
                    state_d        = hit ? RESP : SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                bus.rom_cs = 1'b1;
                bus.rom_en = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPTURE: begin
                // output enable stays active so rom_do is still driven when sampled
                bus.rom_en = 1'b0;
                data_d     = bus.rom_do;
                state_d    = RESP;
            end
            RESP: begin
                bus.rsp0_valid = ~gnt_q;
                bus.rsp1_valid = gnt_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign bus.rom_ad   = ad_q;
    assign bus.rsp_data = data_q;

endmodule
